// File: rtl/narrow_64_to_32.sv
// Width converter: registers each accepted 64-bit word and replays it as two
// 32-bit beats. HIGH_FIRST selects which half is sent first.
module narrow_64_to_32 #(
    parameter bit HIGH_FIRST = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_enq_valid,
    input  logic [63:0] io_enq_bits_data,
    output logic        io_enq_ready,
    input  logic        io_deq_ready,
    output logic        io_deq_valid,
    output logic [31:0] io_deq_bits_data,
    output logic        io_deq_bits_last
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [63:0] r_holdData;
    logic        w_enqFire;
    logic        w_deqFire;
    logic [31:0] w_firstHalf;
    logic [31:0] w_secondHalf;

    assign w_enqFire    = io_enq_valid & io_enq_ready;
    assign w_deqFire    = io_deq_valid & io_deq_ready;
    assign w_firstHalf  = HIGH_FIRST ? r_holdData[63:32] : r_holdData[31:0];
    assign w_secondHalf = HIGH_FIRST ? r_holdData[31:0]  : r_holdData[63:32];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_holdData <= 64'd0;
        end else if (w_enqFire) begin
            r_holdData <= io_enq_bits_data;
        end
    end

    // A new word may be taken while the second beat leaves, keeping one beat per cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            EMPTY: begin
                if (w_enqFire) w_nextState = FIRST;
            end
            FIRST: begin
                if (w_deqFire) w_nextState = SECOND;
            end
            SECOND: begin
                if (w_deqFire && w_enqFire)      w_nextState = FIRST;
                else if (w_deqFire)              w_nextState = EMPTY;
            end
            default: w_nextState = EMPTY;
        endcase
    end

    always_comb begin
        io_enq_ready     = 1'b0;
        io_deq_valid     = 1'b0;
        io_deq_bits_data = 32'd0;
        io_deq_bits_last = 1'b0;
        case (r_state)
            EMPTY: begin
                io_enq_ready = reset;
            end
            FIRST: begin
                io_deq_valid     = 1'b1;
                io_deq_bits_data = w_firstHalf;
            end
            SECOND: begin
                io_enq_ready     = reset & io_deq_ready;
                io_deq_valid     = 1'b1;
                io_deq_bits_data = w_secondHalf;
                io_deq_bits_last = 1'b1;
            end
            default: begin
                io_enq_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/narrow_64_to_32.md
NARROW_64_TO_32 -- requirements
Module: narrow_64_to_32

Interface
REQ-001 Parameter: HIGH_FIRST, 0, when 1 the upper half [63:32] is emitted first; when 0 the lower half [31:0] is emitted first.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 io_enq_valid  input  1  upstream 64-bit word valid.
REQ-005 io_enq_bits_data  input  64  upstream word.
REQ-006 io_enq_ready  output  1  block accepts io_enq_bits_data this cycle.
REQ-007 io_deq_ready  input  1  downstream accepts a 32-bit beat this cycle.
REQ-008 io_deq_valid  output  1  beat on io_deq_bits_data is valid.
REQ-009 io_deq_bits_data  output  32  current half-word beat.
REQ-010 io_deq_bits_last  output  1  high on the second beat of each word.

Function
REQ-011 The block SHALL consume the 64-bit stream from the flow-through entry queue and SHALL register every accepted word, so no combinational path exists from io_enq_bits_data or io_enq_valid to any output.
REQ-012 The state machine SHALL have three states: EMPTY, FIRST (word held, first beat pending), SECOND (word held, second beat pending).
REQ-013 Enqueue fire SHALL be io_enq_valid & io_enq_ready; dequeue fire SHALL be io_deq_valid & io_deq_ready.
REQ-014 io_enq_ready SHALL equal (state==EMPTY) | (state==SECOND & io_deq_ready), and SHALL NOT depend on io_enq_valid.
REQ-015 io_deq_valid SHALL equal (state!=EMPTY).
REQ-016 In FIRST, io_deq_bits_data SHALL be the first half per HIGH_FIRST and io_deq_bits_last SHALL be 0.
REQ-017 In SECOND, io_deq_bits_data SHALL be the other half and io_deq_bits_last SHALL be 1.
REQ-018 In EMPTY, io_deq_bits_data and io_deq_bits_last SHALL be 0.
REQ-019 Transitions: EMPTY -> FIRST on enqueue fire; FIRST -> SECOND on dequeue fire; SECOND -> EMPTY on dequeue fire without enqueue fire; SECOND -> FIRST on simultaneous dequeue and enqueue fire; otherwise hold.
REQ-020 The holding register SHALL load io_enq_bits_data only on enqueue fire and SHALL otherwise hold.
REQ-021 Latency: a word accepted in cycle N SHALL present its first beat in cycle N+1.
REQ-022 Throughput: with io_enq_valid and io_deq_ready continuously high, the block SHALL emit one beat per cycle with no bubbles (one word per two cycles).
REQ-023 Backpressure: while io_deq_ready is low, state, holding register and outputs SHALL remain stable; io_enq_ready SHALL be 0 unless state is EMPTY.
REQ-024 A beat SHALL never be dropped or duplicated; the beat order SHALL be first, second, per word, in acceptance order.

Reset
REQ-025 On reset low, the state SHALL go to EMPTY and the holding register SHALL go to 0 immediately, regardless of clock.
REQ-026 While reset is low, io_deq_valid SHALL be 0 and io_enq_ready SHALL be 0.
REQ-027 Reset asserted mid-word (in FIRST or SECOND) SHALL discard the held word; after release the first output SHALL be the first beat of the next accepted word.
REQ-028 In the first clock edge after reset release, io_enq_ready SHALL be 1 and io_deq_valid SHALL be 0.

Verification
REQ-029 HIGH_FIRST=0, enqueue 0x1122334455667788, io_deq_ready=1 -> beats 0x55667788 (last=0), then 0x11223344 (last=1), on cycles N+1, N+2.
REQ-030 HIGH_FIRST=1, same word -> beats 0x11223344 (last=0), then 0x55667788 (last=1).
REQ-031 Stream 4 words back-to-back, io_deq_ready=1 -> 8 beats on 8 consecutive cycles, last toggling 0,1, io_enq_ready high every other cycle from SECOND.
REQ-032 Word held in FIRST, io_deq_ready low 5 cycles -> beat data, last and io_deq_valid stable; io_enq_ready=0; no state change.
REQ-033 Word in SECOND, io_enq_valid=1, io_deq_ready=1 -> second beat fires and new word is accepted in the same cycle; next cycle shows the new word's first beat.
REQ-034 Assert reset during SECOND, release, enqueue 0xAAAAAAAA_BBBBBBBB -> no residual beat; first beat after release is 0xBBBBBBBB (HIGH_FIRST=0).
